// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the register-file write-back path.
// One operation in flight: shift-add multiply or restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH    = 16,
  parameter int REG_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  input  logic [REG_ID_W-1:0] dst_id,
  output logic                busy,
  output logic                pend_valid,
  output logic [REG_ID_W-1:0] pend_id,
  output logic                wb_en,
  output logic [REG_ID_W-1:0] wb_reg,
  output logic [WIDTH-1:0]    wb_data
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [REG_ID_W-1:0] dst_q, dst_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_ID_W-1:0] wb_reg_q, wb_reg_d;
  logic [WIDTH-1:0]    wb_data_q, wb_data_d;

  // hi/lo form the product {hi,lo} for MUL and {remainder, quotient} for DIV;
  // opnd holds the multiplicand (MUL) or the divisor (DIV).
  logic [WIDTH:0] mul_sum_s;
  logic [WIDTH:0] div_trial_s;
  logic [WIDTH:0] div_diff_s;
  logic           div_ge_s;

  assign mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_trial_s = {hi_q, lo_q[WIDTH-1]};
  assign div_ge_s    = (div_trial_s >= {1'b0, opnd_q});
  assign div_diff_s  = div_trial_s - {1'b0, opnd_q};

  // Next-state, datapath iteration and write-back staging
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dst_d     = dst_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          dst_d  = dst_id;
          cnt_d  = {CNT_W{1'b0}};
          busy_d = 1'b1;
          hi_d   = {WIDTH{1'b0}};
          if (op[1]) begin
            opnd_d = src_b;
            lo_d   = src_a;
          end else begin
            opnd_d = src_a;
            lo_d   = src_b;
          end
          if (op[1] && (src_b == {WIDTH{1'b0}})) begin
            state_d   = S_DONE;
            wb_en_d   = 1'b1;
            wb_reg_d  = dst_id;
            wb_data_d = op[0] ? src_a : {WIDTH{1'b1}};
          end else begin
            state_d   = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = {mul_sum_s, lo_q[WIDTH-1:1]};
        end else begin
          hi_d = div_ge_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge_s};
        end
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          wb_en_d   = 1'b1;
          wb_reg_d  = dst_q;
          wb_data_d = op_q[0] ? hi_d : lo_d;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      op_q      <= 2'b00;
      dst_q     <= {REG_ID_W{1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= {REG_ID_W{1'b0}};
      wb_data_q <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy       = busy_q;
  assign pend_valid = busy_q;
  assign pend_id    = dst_q;
  assign wb_en      = wb_en_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an operation-level reference model checked every cycle,
// plus hand-computed results and latencies for directed cases.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] src_a = 16'h0000;
  logic [15:0] src_b = 16'h0000;
  logic [3:0]  dst_id = 4'h0;
  logic        busy, pend_valid, wb_en;
  logic [3:0]  pend_id, wb_reg;
  logic [15:0] wb_data;

  int checks = 0;
  int failures = 0;
  int wb_seen = 0;

  muldiv_unit #(.WIDTH(16), .REG_ID_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst_id(dst_id), .busy(busy), .pend_valid(pend_valid), .pend_id(pend_id),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0000, a} * {16'h0000, b};
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0000) ? 16'hFFFF : a / b;
      default: return (b == 16'h0000) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [15:0] b);
    return (o[1] && b == 16'h0000) ? 1 : 17;
  endfunction

  // Operation-level model: cycles remaining until busy drops, result and destination
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [15:0] m_res = 16'h0000, m_data = 16'h0000;
  logic [3:0]  m_dst = 4'h0, m_reg = 4'h0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_left = 0; m_data = 16'h0000; m_reg = 4'h0; m_dst = 4'h0;
    end else begin
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_left = ref_latency(op, src_b);
          m_res  = ref_result(op, src_a, src_b);
          m_dst  = dst_id;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end
      if (m_busy && m_left == 1) begin
        m_data = m_res;
        m_reg  = m_dst;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("busy", busy, m_busy);
      chk("pend_valid", pend_valid, m_busy);
      chk("wb_en", wb_en, m_busy && m_left == 1);
      chk("wb_reg", wb_reg, m_reg);
      chk("wb_data", wb_data, m_data);
      if (m_busy) chk("pend_id", pend_id, m_dst);
      if (wb_en) wb_seen++;
    end
  end

  // Issue one op at a negedge, wait for wb_en, check against given literals.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input logic [15:0] exp, input int lat, input bit noise);
    int n;
    op = o; src_a = a; src_b = b; dst_id = d; start = 1'b1;
    @(negedge clk); n = 1;
    start = 1'b0;
    while (!wb_en && n < 40) begin
      if (noise) begin
        start = $urandom_range(0, 1); src_a = 16'($urandom); src_b = 16'($urandom);
        dst_id = 4'($urandom); op = 2'($urandom);
      end
      @(negedge clk); n++;
    end
    start = 1'b0;
    chk("latency", n, lat);
    chk("result", wb_data, exp);
    chk("result_reg", wb_reg, d);
    @(negedge clk);
    chk("busy_after_wb", busy, 1'b0);
  endtask

  initial begin
    int base;
    #12;
    chk("reset_busy", busy, 1'b0);
    chk("reset_wb_en", wb_en, 1'b0);
    chk("reset_wb_data", wb_data, 16'h0000);
    chk("reset_pend_id", pend_id, 4'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    run_op(2'b00, 16'h0003, 16'h0005, 4'd4, 16'h000F, 17, 1'b0);
    run_op(2'b01, 16'h1234, 16'h0100, 4'd2, 16'h0012, 17, 1'b0);
    run_op(2'b00, 16'h1234, 16'h0100, 4'd3, 16'h3400, 17, 1'b1);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 4'd0, 16'hFFFE, 17, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0001, 17, 1'b0);
    run_op(2'b10, 16'h0064, 16'h0007, 4'd5, 16'h000E, 17, 1'b0);
    run_op(2'b11, 16'h0064, 16'h0007, 4'd6, 16'h0002, 17, 1'b1);
    run_op(2'b10, 16'h0005, 16'h0009, 4'd7, 16'h0000, 17, 1'b0);
    run_op(2'b11, 16'h0005, 16'h0009, 4'd8, 16'h0005, 17, 1'b0);
    run_op(2'b10, 16'h1234, 16'h0000, 4'd9, 16'hFFFF, 1, 1'b0);
    run_op(2'b11, 16'h1234, 16'h0000, 4'd10, 16'h1234, 1, 1'b0);

    // start while busy is ignored; operands latched at acceptance
    base = wb_seen;
    op = 2'b00; src_a = 16'h0002; src_b = 16'h0003; dst_id = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b10; src_a = 16'h0777; src_b = 16'h0009; dst_id = 4'd12; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("pend_id_mid", pend_id, 4'd1);
    repeat (25) @(negedge clk);
    chk("single_wb", wb_seen - base, 1);
    chk("latched_data", wb_data, 16'h0006);
    chk("latched_reg", wb_reg, 4'd1);

    // reset mid-operation
    op = 2'b01; src_a = 16'hABCD; src_b = 16'h1234; dst_id = 4'd11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    base = wb_seen;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_pend_valid", pend_valid, 1'b0);
    chk("rst_wb_en", wb_en, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_wb_after_abort", wb_seen - base, 0);
    run_op(2'b00, 16'h0100, 16'h0100, 4'd13, 16'h0000, 17, 1'b0);

    // randomized ops against the reference functions
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [15:0] ra, rb;
      ro = 2'($urandom);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 15));
      run_op(ro, ra, rb, 4'($urandom), ref_result(ro, ra, rb), ref_latency(ro, rb), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
